// File: rtl/game_status_ctrl_if.sv
// Signal bundle between the game front panel / game logic and the status controller.
// The master side drives the raw buttons and the collision event; the slave side
// (the controller) returns the game status, the one-second tick and the FSM state.
interface game_status_ctrl_if;
    logic       btn_start;
    logic       btn_pause;
    logic       collision;
    logic       status;
    logic       tick_1Hz;
    logic       game_over;
    logic [1:0] state;

    modport master (
        output btn_start,
        output btn_pause,
        output collision,
        input  status,
        input  tick_1Hz,
        input  game_over,
        input  state
    );

    modport slave (
        input  btn_start,
        input  btn_pause,
        input  collision,
        output status,
        output tick_1Hz,
        output game_over,
        output state
    );
endinterface

// File: rtl/game_status_ctrl.sv
// Game status controller: synchronizes and debounces the start/pause buttons,
// synchronizes the collision event, runs the IDLE/RUN/PAUSE/OVER game FSM and
// produces a one-cycle tick per elapsed second of RUN time.
module game_status_ctrl #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    game_status_ctrl_if.slave bus
);

    // Counter widths; a one-bit floor keeps degenerate parameter values legal.
    localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    // Synchronizer bit order: 0 = start button, 1 = pause button, 2 = collision.
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;

    // Debounce bit order: 0 = start button, 1 = pause button.
    logic [1:0]       deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];
    logic [1:0]       deb_prev_q, deb_prev_d;
    logic [1:0]       press_q, press_d;

    logic [1:0]       state_q, state_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;

    logic             start_press;
    logic             pause_press;
    logic             coll_sync;
    logic             sec_terminal;

    assign start_press  = press_q[0];
    assign pause_press  = press_q[1];
    assign coll_sync    = sync2_q[2];
    assign sec_terminal = (sec_cnt_q == SEC_LAST);

    // Two-flop synchronizer stages for all three asynchronous inputs.
    always_comb begin
        sync1_d = {bus.collision, bus.btn_pause, bus.btn_start};
        sync2_d = sync1_q;
    end

    // Debounce: a button level is accepted only after the synchronized level has
    // differed from it for DEBOUNCE_CYCLES cycles in a row; any return clears the run.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press pulses fire for one cycle after the debounced level rises.
    always_comb begin
        deb_prev_d = deb_q;
        press_d    = deb_q & ~deb_prev_q;
    end

    // Game FSM; collision beats pause in RUN, and a held collision cannot
    // re-enter OVER because only RUN looks at it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (coll_sync) begin
                    state_d = ST_OVER;
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_press || start_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start_press) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Second counter counts RUN cycles only, keeps partial progress across a pause
    // and restarts from zero whenever the game is idle or over.
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (sec_terminal) begin
                    sec_cnt_d = '0;
                end else begin
                    sec_cnt_d = sec_cnt_q + 1'b1;
                end
            end
            ST_PAUSE: sec_cnt_d = sec_cnt_q;
            default:  sec_cnt_d = '0;
        endcase
    end

    // All state registers share one asynchronous reset that discards any progress.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            deb_prev_q   <= '0;
            press_q      <= '0;
            state_q      <= ST_IDLE;
            sec_cnt_q    <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
            deb_prev_q   <= deb_prev_d;
            press_q      <= press_d;
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
        end
    end

    // Outputs are plain decodes of the registered state, so they follow it without delay.
    assign bus.state     = state_q;
    assign bus.status    = (state_q == ST_RUN);
    assign bus.game_over = (state_q == ST_OVER);
    assign bus.tick_1Hz  = (state_q == ST_RUN) && sec_terminal;

endmodule
